// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock hour counter.
//   hour_state_t : FSM encoding for the hour sequencer
//   HOUR_*       : binary hour limits and midnight values per display mode
package clock_pkg;

  localparam int unsigned HOUR_W = 5;

  typedef enum logic [1:0] {IDLE, CHECK, INC, WRAP} hour_state_t;

  localparam logic [HOUR_W-1:0] HOUR_MAX_12 = 5'd12;
  localparam logic [HOUR_W-1:0] HOUR_MAX_24 = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR_RST_12 = 5'd12;
  localparam logic [HOUR_W-1:0] HOUR_RST_24 = 5'd0;

endpackage

// File: rtl/hours_if.sv
// Hour counter bus: advance pulses in, BCD hour digits / pm / changeDay out.
//   changeHour, advHour : one-cycle advance requests (auto from minutes, manual)
//   hourMSB, hourLSB    : BCD tens / units of the displayed hour
//   pm, changeDay       : PM flag and midnight-rollover pulse
interface hours_if;
  logic       changeHour;
  logic       advHour;
  logic [1:0] hourMSB;
  logic [3:0] hourLSB;
  logic       pm;
  logic       changeDay;

  modport master (output changeHour, advHour,
                  input  hourMSB, hourLSB, pm, changeDay);
  modport slave  (input  changeHour, advHour,
                  output hourMSB, hourLSB, pm, changeDay);
endinterface

// File: rtl/hour_next.sv
// Combinational successor of the current hour in the selected display mode.
//   i_hour, i_pm   : current binary hour and pm flag
//   o_hour, o_pm   : hour/pm after one non-wrapping advance
//   o_is_last      : current hour is the last before midnight
//   o_msb, o_lsb   : BCD split of o_hour
module hour_next
  import clock_pkg::*;
#(
  parameter bit MODE_24H = 1'b0
) (
  input  logic [HOUR_W-1:0] i_hour,
  input  logic              i_pm,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_pm,
  output logic              o_is_last,
  output logic [1:0]        o_msb,
  output logic [3:0]        o_lsb
);

  logic [HOUR_W-1:0] w_base;

  // Successor hour and pm; 12h mode counts 12,1..11 and flips pm entering 12
  always_comb begin
    o_hour    = i_hour + 5'd1;
    o_pm      = 1'b0;
    o_is_last = 1'b0;
    if (MODE_24H) begin
      o_is_last = (i_hour == HOUR_MAX_24);
      if (i_hour == HOUR_MAX_24) o_hour = 5'd0;
    end else begin
      o_is_last = (i_hour == 5'd11) && i_pm;
      o_pm      = (i_hour == 5'd11) ? ~i_pm : i_pm;
      if (i_hour == HOUR_MAX_12) o_hour = 5'd1;
    end
  end

  // Binary to BCD for 0..23
  always_comb begin
    o_msb  = 2'd0;
    w_base = 5'd0;
    if (o_hour >= 5'd20) begin
      o_msb  = 2'd2;
      w_base = 5'd20;
    end else if (o_hour >= 5'd10) begin
      o_msb  = 2'd1;
      w_base = 5'd10;
    end
    o_lsb = 4'(o_hour - w_base);
  end

endmodule

// File: rtl/hours.sv
// Hour counter: queues auto/manual advance pulses and steps the hour through
// IDLE -> CHECK -> INC/WRAP, with registered BCD digits, pm and changeDay.
//   clkMSec, reset : clock and synchronous active-high reset
//   bus (slave)    : changeHour/advHour in; hourMSB/hourLSB/pm/changeDay out
module hours
  import clock_pkg::*;
#(
  parameter bit MODE_24H = 1'b0
) (
  input  logic clkMSec,
  input  logic reset,
  hours_if.slave bus
);

  localparam logic [HOUR_W-1:0] L_MID_HOUR = MODE_24H ? HOUR_RST_24 : HOUR_RST_12;
  localparam logic [1:0]        L_MID_MSB  = MODE_24H ? 2'd0 : 2'd1;
  localparam logic [3:0]        L_MID_LSB  = MODE_24H ? 4'd0 : 4'd2;

  hour_state_t       r_state, w_state_nxt;
  logic              r_pend_auto, r_pend_man, r_src_auto;
  logic [HOUR_W-1:0] r_hour;
  logic              r_pm;
  logic [1:0]        r_msb;
  logic [3:0]        r_lsb;
  logic              r_change_day;

  logic              w_take_auto, w_take_man, w_do_inc, w_do_wrap;
  logic [HOUR_W-1:0] w_nxt_hour;
  logic              w_nxt_pm, w_is_last;
  logic [1:0]        w_nxt_msb;
  logic [3:0]        w_nxt_lsb;

  hour_next #(.MODE_24H(MODE_24H)) u_next (
    .i_hour    (r_hour),
    .i_pm      (r_pm),
    .o_hour    (w_nxt_hour),
    .o_pm      (w_nxt_pm),
    .o_is_last (w_is_last),
    .o_msb     (w_nxt_msb),
    .o_lsb     (w_nxt_lsb)
  );

  // State register
  always_ff @(posedge clkMSec) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-state strobes; auto requests win over manual
  always_comb begin
    w_state_nxt = r_state;
    w_take_auto = 1'b0;
    w_take_man  = 1'b0;
    w_do_inc    = 1'b0;
    w_do_wrap   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_auto) begin
          w_take_auto = 1'b1;
          w_state_nxt = CHECK;
        end else if (r_pend_man) begin
          w_take_man  = 1'b1;
          w_state_nxt = CHECK;
        end
      end
      CHECK:   w_state_nxt = w_is_last ? WRAP : INC;
      INC: begin
        w_do_inc    = 1'b1;
        w_state_nxt = IDLE;
      end
      WRAP: begin
        w_do_wrap   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pending flags, source latch, hour and output registers
  always_ff @(posedge clkMSec) begin
    if (reset) begin
      r_pend_auto  <= 1'b0;
      r_pend_man   <= 1'b0;
      r_src_auto   <= 1'b0;
      r_hour       <= L_MID_HOUR;
      r_pm         <= 1'b0;
      r_msb        <= L_MID_MSB;
      r_lsb        <= L_MID_LSB;
      r_change_day <= 1'b0;
    end else begin
      // a repeat pulse while the flag is set simply merges into it
      r_pend_auto  <= (r_pend_auto & ~w_take_auto) | bus.changeHour;
      r_pend_man   <= (r_pend_man  & ~w_take_man)  | bus.advHour;
      if (w_take_auto || w_take_man) r_src_auto <= w_take_auto;
      r_change_day <= w_do_wrap & r_src_auto;
      if (w_do_inc) begin
        r_hour <= w_nxt_hour;
        r_pm   <= w_nxt_pm;
        r_msb  <= w_nxt_msb;
        r_lsb  <= w_nxt_lsb;
      end else if (w_do_wrap) begin
        r_hour <= L_MID_HOUR;
        r_pm   <= 1'b0;
        r_msb  <= L_MID_MSB;
        r_lsb  <= L_MID_LSB;
      end
    end
  end

  assign bus.hourMSB   = r_msb;
  assign bus.hourLSB   = r_lsb;
  assign bus.pm        = r_pm;
  assign bus.changeDay = r_change_day;

endmodule

// File: tb/tb_hours.sv
// Self-checking bench for hours: a 12h and a 24h instance checked against a
// model that keeps time as hours-since-midnight and derives the display.
module tb_hours;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   t12 = 0;   // model: hours since midnight, 12h instance
  int   t24 = 0;   // model: hours since midnight, 24h instance

  hours_if if12 ();
  hours_if if24 ();

  hours #(.MODE_24H(1'b0)) u_h12 (.clkMSec(clk), .reset(rst), .bus(if12));
  hours #(.MODE_24H(1'b1)) u_h24 (.clkMSec(clk), .reset(rst), .bus(if24));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected {msb, lsb, pm} for time-of-day t in mode m (0 = 12h, 1 = 24h)
  function automatic logic [6:0] disp_exp(input int m, input int t);
    int h;
    bit p;
    if (m == 1) begin
      h = t;
      p = 1'b0;
    end else begin
      h = t % 12;
      if (h == 0) h = 12;
      p = (t >= 12);
    end
    return {2'(h / 10), 4'(h % 10), p};
  endfunction

  function automatic logic [6:0] disp_got(input int m);
    if (m == 0) return {if12.hourMSB, if12.hourLSB, if12.pm};
    return {if24.hourMSB, if24.hourLSB, if24.pm};
  endfunction

  function automatic logic cd_got(input int m);
    return (m == 0) ? if12.changeDay : if24.changeDay;
  endfunction

  task automatic drive(input int m, input bit a, input bit b);
    if (m == 0) begin
      if12.changeHour = a;
      if12.advHour    = b;
    end else begin
      if24.changeHour = a;
      if24.advHour    = b;
    end
  endtask

  // One request (auto, manual or both) from an idle DUT, checked every cycle.
  // Auto completes 4 cycles after the pulse; a queued manual 3 cycles later.
  task automatic txn(input int m, input bit a, input bit b, input string tag);
    int t0, cur, man_c;
    bit cd;
    t0    = (m == 0) ? t12 : t24;
    man_c = a ? 7 : 4;
    drive(m, a, b);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) drive(m, 1'b0, 1'b0);
      cur = t0;
      if (a && c >= 4)     cur = (cur + 1) % 24;
      if (b && c >= man_c) cur = (cur + 1) % 24;
      cd = a && (c == 4) && (t0 == 23);
      check($sformatf("%s_disp_c%0d", tag, c), 32'(disp_got(m)), 32'(disp_exp(m, cur)));
      check($sformatf("%s_cday_c%0d", tag, c), 32'(cd_got(m)), 32'(cd));
    end
    if (m == 0) t12 = cur;
    else        t24 = cur;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    check("rst12_disp", 32'(disp_got(0)), 32'(7'b01_0010_0));
    check("rst12_cday", 32'(cd_got(0)), 32'd0);
    check("rst24_disp", 32'(disp_got(1)), 32'd0);
    check("rst24_cday", 32'(cd_got(1)), 32'd0);

    // 12h: twelve auto steps walk 1..11 AM then 12 PM
    for (int i = 0; i < 12; i++) txn(0, 1'b1, 1'b0, "seq12");
    check("seq12_end", 32'(disp_got(0)), 32'(7'b01_0010_1));

    // 24h: preload to 23, then auto rollover with changeDay
    for (int i = 0; i < 23; i++) txn(1, 1'b1, 1'b0, "pre24");
    check("pre24_at23", 32'(disp_got(1)), 32'(7'b10_0011_0));
    txn(1, 1'b1, 1'b0, "wrap24_auto");

    // 24h: manual rollover at 23 leaves changeDay low
    for (int i = 0; i < 23; i++) txn(1, 1'b0, 1'b1, "pre24m");
    txn(1, 1'b0, 1'b1, "wrap24_man");

    // 24h: simultaneous requests at 05 give 06 then 07
    for (int i = 0; i < 5; i++) txn(1, 1'b1, 1'b0, "pre24b");
    txn(1, 1'b1, 1'b1, "both24");
    check("both24_end", 32'(disp_got(1)), 32'(7'b00_0111_0));

    // randomized mix of request kinds in both modes
    for (int i = 0; i < 60; i++) begin
      int m, k;
      m = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 2));
      txn(m, k != 1, k != 0, $sformatf("rnd%0d", i));
    end

    // reset in INC with a second request pending: all work discarded
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("abort_pre", 32'(disp_got(0)), 32'(disp_exp(0, t12)));
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t12 = 0;
    t24 = 0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("abort_disp_c%0d", c), 32'(disp_got(0)), 32'(disp_exp(0, 0)));
      check($sformatf("abort_cday_c%0d", c), 32'(cd_got(0)), 32'd0);
      @(posedge clk); #1;
    end
    check("abort_rst24", 32'(disp_got(1)), 32'(disp_exp(1, 0)));

    // a fresh request after the abort starts cleanly from midnight
    txn(0, 1'b1, 1'b0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
